sram_master: RTL and testbench
==============================

SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 Parameter ADDR_W, default 5, SRAM word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, SRAM data width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered by host.
REQ-006 cmd_ready  out  1  high only in IDLE; a command SHALL be accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  ADDR_W  burst start address.
REQ-009 cmd_len  in  4  burst length minus 1 (1..16 beats).
REQ-010 wr_valid / wr_data  in  1 / DATA_W  write-beat stream from host.
REQ-011 wr_ready  out  1  high in WRITE state only.
REQ-012 rd_valid / rd_data  out  1 / DATA_W  read-beat stream to host; no backpressure.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 sram_addr / sram_wdata  out  ADDR_W / DATA_W  drive the SRAM Address / WriteData.
REQ-015 sram_we / sram_re  out  1 / 1  drive the SRAM WriteEn / ReadEn.
REQ-016 sram_rdata  in  DATA_W  SRAM ReadData; registered by the SRAM at the edge that samples sram_re.

Function
REQ-017 States SHALL be IDLE, WRITE, READ, DRAIN.
REQ-018 On acceptance, the block SHALL latch addr, len and dir, clear the beat counter, and move to WRITE or READ.
REQ-019 In WRITE, sram_we SHALL equal wr_valid and sram_wdata SHALL equal wr_data, combinationally, in the same cycle; each cycle with wr_valid high consumes one beat; wr_valid low inserts an idle cycle with sram_we low.
REQ-020 In READ, sram_re SHALL be high for exactly len+1 consecutive cycles, one address per cycle.
REQ-021 sram_we and sram_re SHALL never be high in the same cycle.
REQ-022 sram_addr SHALL be start + beat index, truncated to ADDR_W bits; addresses wrap from 2^ADDR_W-1 to 0.
REQ-023 Transitions: after the last write beat, the state SHALL go WRITE->IDLE. After the last sram_re cycle, the state SHALL go READ->DRAIN. DRAIN->IDLE SHALL occur after two cycles, once the final rd_valid has been emitted.
REQ-024 Read data SHALL use a 2-cycle pipeline: for sram_re high in cycle k, rd_valid SHALL be high in cycle k+2 with rd_data = sram_rdata sampled at the end of cycle k+1 (registered).
REQ-025 rd_valid SHALL pulse once per read beat, in address order, with no gaps within a burst.
REQ-026 cmd_ready SHALL be low from the acceptance cycle until IDLE is re-entered; back-to-back commands are therefore separated by at least one cycle.
REQ-027 When sram_we and sram_re are both low, sram_addr and sram_wdata SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-028 While rst_n is low, state SHALL be IDLE, the counter 0, and sram_we, sram_re, rd_valid and busy 0; cmd_ready SHALL be 1 after release.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no further SRAM strobes, and any in-flight read beats SHALL be dropped.

Structure
REQ-030 A shared package SHALL hold the state enum, the cmd_len width (4), and the default ADDR_W and DATA_W.
REQ-031 The read-return pipeline (delayed sram_re plus data register) SHALL be one sub-module, sram_rd_pipe.

Verification
REQ-032 Write addr 3, len 3, data A0..A3 with no stalls -> sram_we high for 4 consecutive cycles at addresses 3,4,5,6; back in IDLE the cycle after the last beat.
REQ-033 Read back addr 3, len 3 -> rd_data A0,A1,A2,A3 on 4 consecutive rd_valid cycles, the first 2 cycles after the first sram_re.
REQ-034 Write addr 30, len 3, then read the same -> addresses 30,31,0,1; data intact.
REQ-035 Write burst with wr_valid low on beat 2 for 3 cycles -> sram_we low for those 3 cycles; 4 beats total; addresses contiguous.
REQ-036 rst_n pulsed low during beat 2 of a 16-beat read -> sram_re drops in the same cycle; no rd_valid after reset; cmd_ready = 1 after release.
REQ-037 cmd_valid held high across a burst -> second command accepted only in IDLE; sram_we and sram_re never both high.

Source files
------------

// File: rtl/sram_master_pkg.sv
// Shared types and defaults for the SRAM burst master.
package sram_master_pkg;

    localparam int CMD_LEN_W  = 4;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sram_master_if.sv
// Host command/data streams and SRAM strobes of the burst master, bundled in one bus.
interface sram_master_if #(
    parameter int ADDR_W = sram_master_pkg::DEF_ADDR_W,
    parameter int DATA_W = sram_master_pkg::DEF_DATA_W
);

    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic                                 cmd_write;
    logic [ADDR_W-1:0]                    cmd_addr;
    logic [sram_master_pkg::CMD_LEN_W-1:0] cmd_len;
    logic                                 wr_valid;
    logic [DATA_W-1:0]                    wr_data;
    logic                                 wr_ready;
    logic                                 rd_valid;
    logic [DATA_W-1:0]                    rd_data;
    logic                                 busy;
    logic [ADDR_W-1:0]                    sram_addr;
    logic [DATA_W-1:0]                    sram_wdata;
    logic                                 sram_we;
    logic                                 sram_re;
    logic [DATA_W-1:0]                    sram_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, sram_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy,
               sram_addr, sram_wdata, sram_we, sram_re
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, sram_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
               sram_addr, sram_wdata, sram_we, sram_re
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: delays the read strobe one cycle, then registers SRAM data with a valid flag.
module sram_rd_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_re,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_re_d;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // SRAM data is valid the cycle after sram_re; capture it at the end of that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_d  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_re_d  <= i_re;
            r_valid <= r_re_d;
            if (r_re_d) begin
                r_data <= i_rdata;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/sram_master.sv
// Burst master turning host write/read commands into single-port SRAM strobe sequences.
//   state | meaning
//   IDLE  | ready for a command
//   WRITE | one SRAM write per cycle with wr_valid high
//   READ  | one SRAM read per cycle, len+1 cycles
//   DRAIN | two cycles waiting for the last read beat to return
module sram_master
    import sram_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_master_if.master bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_base;
    logic [ADDR_W-1:0]     w_base_nxt;
    logic [CMD_LEN_W-1:0]  r_len;
    logic [CMD_LEN_W-1:0]  w_len_nxt;
    logic [CMD_LEN_W-1:0]  r_cnt;
    logic [CMD_LEN_W-1:0]  w_cnt_nxt;
    logic                  w_last;
    logic                  w_we;
    logic                  w_re;
    logic                  w_cmd_ready;
    logic                  w_wr_ready;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_rd_valid;
    logic [DATA_W-1:0]     w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_cmd_ready = 1'b0;
        w_wr_ready  = 1'b0;
        w_last      = (r_cnt == r_len);
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_base_nxt  = bus.cmd_addr;
                    w_len_nxt   = bus.cmd_len;
                    w_cnt_nxt   = '0;
                    w_state_nxt = bus.cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_wr_ready = 1'b1;
                w_we       = bus.wr_valid;
                if (bus.wr_valid) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_READ: begin
                w_re = 1'b1;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                // counter is reused to time the two drain cycles
                if (r_cnt == CMD_LEN_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // address wraps naturally by truncation to ADDR_W bits
    always_comb begin
        w_addr = r_base + ADDR_W'(r_cnt);
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_re    (w_re),
        .i_rdata (bus.sram_rdata),
        .o_valid (w_rd_valid),
        .o_data  (w_rd_data)
    );

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.sram_we    = w_we;
    assign bus.sram_re    = w_re;
    assign bus.sram_addr  = w_addr;
    assign bus.sram_wdata = bus.wr_data;
    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_data    = w_rd_data;

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural SRAM and a strobe/beat monitor.
module tb_sram_master;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_re) bus.sram_rdata <= mem[bus.sram_addr];
    end

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ev_t;

    ev_t wq[$];
    ev_t rq[$];
    ev_t vq[$];
    int  acc[$];
    int  cyc       = 0;
    int  conflicts = 0;
    int  checks    = 0;
    int  failures  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sram_we) wq.push_back('{cyc, bus.sram_addr, bus.sram_wdata});
        if (bus.sram_re) rq.push_back('{cyc, bus.sram_addr, '0});
        if (bus.rd_valid) vq.push_back('{cyc, '0, bus.rd_data});
        if (bus.sram_we && bus.sram_re) conflicts <= conflicts + 1;
        if (bus.cmd_valid && bus.cmd_ready) acc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [3:0] l, output bit ok);
        ok = 1'b0;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #2;
            if (bus.cmd_ready) ok = 1'b1;
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] l, input logic [DW-1:0] d0,
                            input int stall_beat, input int stall_n, output bit ok);
        send_cmd(1'b1, a, l, ok);
        for (int b = 0; b <= int'(l); b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.wr_valid = 1'b0;
                    tick();
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = d0 + DW'(b);
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [3:0] l, output bit ok);
        send_cmd(1'b0, a, l, ok);
        repeat (int'(l) + 3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #2;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.sram_we); end
        checks++; if (bus.sram_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", bus.sram_re); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        rst_n = 1'b1;
        tick();
        #2;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        tick();
    endtask

    task automatic test_write_basic();
        bit ok;
        logic [AW-1:0] ea [4] = '{5'd3, 5'd4, 5'd5, 5'd6};
        wq.delete();
        do_write(5'd3, 4'd3, 32'hA0, -1, 0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_accept got=%b exp=1", ok); end
        #2;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_idle_after got busy=%b exp=0", bus.busy); end
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL wr_beats got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== ea[i] || wq[i].d !== 32'hA0 + DW'(i) || wq[i].c != wq[0].c + i) begin
                failures++;
                $display("FAIL wr_beat%0d got a=%0d d=%h c=+%0d exp a=%0d d=%h c=+%0d",
                         i, wq[i].a, wq[i].d, wq[i].c - wq[0].c, ea[i], 32'hA0 + DW'(i), i);
            end
        end
        tick();
    endtask

    task automatic test_read_basic();
        bit ok;
        rq.delete();
        vq.delete();
        do_read(5'd3, 4'd3, ok);
        #2;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rd_accept got=%b exp=1", ok); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rd_idle_after got busy=%b exp=0", bus.busy); end
        checks++; if (rq.size() != 4 || vq.size() != 4) begin failures++; $display("FAIL rd_counts got re=%0d valid=%0d exp 4/4", rq.size(), vq.size()); end
        if (rq.size() == 4 && vq.size() == 4) begin
            checks++; if (vq[0].c != rq[0].c + 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", vq[0].c - rq[0].c); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rq[i].a !== AW'(3 + i) || vq[i].d !== 32'hA0 + DW'(i) || vq[i].c != vq[0].c + i || rq[i].c != rq[0].c + i) begin
                    failures++;
                    $display("FAIL rd_beat%0d got a=%0d d=%h exp a=%0d d=%h", i, rq[i].a, vq[i].d, 3 + i, 32'hA0 + DW'(i));
                end
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        bit ok;
        logic [AW-1:0] ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        wq.delete();
        rq.delete();
        vq.delete();
        do_write(5'd30, 4'd3, 32'hC0, -1, 0, ok);
        tick();
        do_read(5'd30, 4'd3, ok);
        checks++; if (wq.size() != 4 || rq.size() != 4 || vq.size() != 4) begin
            failures++; $display("FAIL wrap_counts got we=%0d re=%0d valid=%0d exp 4/4/4", wq.size(), rq.size(), vq.size());
        end
        for (int i = 0; i < 4 && i < wq.size() && i < rq.size() && i < vq.size(); i++) begin
            checks++;
            if (wq[i].a !== ea[i] || rq[i].a !== ea[i] || vq[i].d !== 32'hC0 + DW'(i)) begin
                failures++;
                $display("FAIL wrap_beat%0d got wa=%0d ra=%0d d=%h exp a=%0d d=%h", i, wq[i].a, rq[i].a, vq[i].d, ea[i], 32'hC0 + DW'(i));
            end
        end
        tick();
    endtask

    task automatic test_stall();
        bit ok;
        int eoff [4] = '{0, 1, 5, 6};
        wq.delete();
        vq.delete();
        do_write(5'd10, 4'd3, 32'hB0, 2, 3, ok);
        #2;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stall_idle_after got busy=%b exp=0", bus.busy); end
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL stall_beats got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== AW'(10 + i) || wq[i].c != wq[0].c + eoff[i]) begin
                failures++;
                $display("FAIL stall_beat%0d got a=%0d c=+%0d exp a=%0d c=+%0d", i, wq[i].a, wq[i].c - wq[0].c, 10 + i, eoff[i]);
            end
        end
        tick();
        do_read(5'd10, 4'd3, ok);
        checks++; if (vq.size() != 4) begin failures++; $display("FAIL stall_rd_count got=%0d exp=4", vq.size()); end
        for (int i = 0; i < 4 && i < vq.size(); i++) begin
            checks++;
            if (vq[i].d !== 32'hB0 + DW'(i)) begin failures++; $display("FAIL stall_rd%0d got=%h exp=%h", i, vq[i].d, 32'hB0 + DW'(i)); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        acc.delete();
        vq.delete();
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 5'd3;
        bus.cmd_len   = 4'd1;
        bus.cmd_valid = 1'b1;
        repeat (11) tick();
        bus.cmd_valid = 1'b0;
        repeat (6) tick();
        #2;
        checks++; if (acc.size() != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
        if (acc.size() == 3) begin
            checks++; if (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5) begin
                failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=5,5", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        checks++; if (vq.size() != 6) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=6", vq.size()); end
        for (int i = 0; i < 6 && i < vq.size(); i++) begin
            checks++;
            if (vq[i].d !== 32'hA0 + DW'(i % 2)) begin failures++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, vq[i].d, 32'hA0 + DW'(i % 2)); end
        end
        checks++; if (conflicts != 0) begin failures++; $display("FAIL we_re_overlap got=%0d exp=0", conflicts); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got busy=%b exp=0", bus.busy); end
        tick();
    endtask

    task automatic test_reset_midburst();
        bit ok;
        send_cmd(1'b0, 5'd0, 4'd15, ok);
        tick();
        tick();
        #1;
        checks++; if (bus.sram_re !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_re got=%b exp=1", bus.sram_re); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sram_re !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_abort got re=%b busy=%b exp 0/0", bus.sram_re, bus.busy);
        end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_valid got=%b exp=0", bus.rd_valid); end
        rq.delete();
        vq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        #2;
        checks++; if (rq.size() != 0 || vq.size() != 0) begin
            failures++; $display("FAIL rst_mid_after got re=%0d valid=%0d exp 0/0", rq.size(), vq.size());
        end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_cmd_ready got=%b exp=1", bus.cmd_ready); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
